// File: rtl/auto_alert_seq.sv
// ============================================================================
// auto_alert_seq : sensor sync/debounce, sticky alarms, round-robin RGB LED
// Optional blinking SHOW phase: define AUTO_ALERT_BLINK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module auto_alert_seq #(
    parameter int DEB_CYCLES   = 16,
    parameter int SLOT_CYCLES  = 64,
    parameter int GAP_CYCLES   = 8,
    parameter int BLINK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ct,
    input  logic       cl,
    input  logic       ot,
    input  logic       ol,
    input  logic       ack,
    output logic [2:0] RGB,
    output logic [3:0] alarm,
    output logic       busy
);

    localparam int DW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int SMAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(SMAX);

    if (DEB_CYCLES < 2 || SLOT_CYCLES < 2 || GAP_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
        $error("auto_alert_seq: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [4:0] sync1_q, sync2_q;
    logic [3:0] deb;
    logic       ack_prev_q;
    logic       ack_rise;
    logic [3:0] alarm_q, alarm_d;
    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [1:0] sel, cand;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] rgb_q, rgb_d;
    logic       blink_on;

    // Bit 4 carries ack; bits 3..0 are the sensor channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            ack_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {ack, ol, ot, cl, ct};
            sync2_q    <= sync1_q;
            ack_prev_q <= sync2_q[4];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [DW-1:0] cnt_q;
        logic          lvl_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[i] != lvl_q) begin
                if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                    cnt_q <= '0;
                    lvl_q <= ~lvl_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign deb[i] = lvl_q;
    end

    assign ack_rise = sync2_q[4] & ~ack_prev_q;
    // Set wins: a still-asserted channel survives the acknowledge.
    assign alarm_d  = (ack_rise ? (alarm_q & deb) : alarm_q) | deb;

    always_comb begin
        sel  = ptr_q;
        cand = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (alarm_q[cand]) begin
                sel = cand;
            end
        end
    end

    function automatic logic [2:0] colour(input logic [1:0] ch);
        case (ch)
            2'd0:    colour = 3'b100;
            2'd1:    colour = 3'b101;
            2'd2:    colour = 3'b110;
            default: colour = 3'b001;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|alarm_q) begin
                    state_d = S_SHOW;
                    idx_d   = sel;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (!alarm_q[idx_q] || cnt_q == CW'(SLOT_CYCLES - 1)) begin
                    state_d = S_GAP;
                    ptr_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (|alarm_q) begin
                        state_d = S_SHOW;
                        idx_d   = sel;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTO_ALERT_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_CYCLES);

    logic [BW-1:0] blink_q, blink_d;

    always_comb begin
        blink_d = blink_q + 1'b1;
        if ((state_d == S_SHOW && state_q != S_SHOW) || blink_q == BW'(2 * BLINK_CYCLES - 1)) begin
            blink_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink_on = (blink_d < BW'(BLINK_CYCLES));
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin
        case (state_d)
            S_IDLE:  rgb_d = 3'b010;
            S_SHOW:  rgb_d = blink_on ? colour(idx_d) : 3'b000;
            default: rgb_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            alarm_q <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            rgb_q   <= rgb_d;
        end
    end

    assign RGB   = rgb_q;
    assign alarm = alarm_q;
    assign busy  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/auto_alert_seq.md
# auto_alert_seq

Sequential alarm controller for the automotive sensor datapath (ct/cl/ot/ol sensors driving the RGB LED). Synchronizes and debounces the four sensor inputs and latches each as a sticky alarm until the driver acknowledges it. A round-robin scheduler time-shares the single RGB LED among the active alarms, one colour per alarm. It replaces direct combinational sensor-to-RGB decoding on the Boolean board.

## Interface
- DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a level change (≥2).
- SLOT_CYCLES, 64, cycles one alarm colour is shown per turn (≥2).
- GAP_CYCLES, 8, dark cycles between turns (≥1).
- BLINK_CYCLES, 8, blink half-period; used only when blinking is compiled in.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ct  in  1  coolant-temperature sensor, async, active-high; channel 0.
- cl  in  1  coolant-level sensor; channel 1.
- ot  in  1  oil-temperature sensor; channel 2.
- ol  in  1  oil-level sensor; channel 3.
- ack  in  1  driver acknowledge button, async, active-high.
- RGB  out  3  LED drive {R,G,B}, registered.
- alarm  out  4  sticky alarm flags, bit i = channel i, registered.
- busy  out  1  high when the scheduler is not in IDLE.

## Operation
- Sync: every input (including ack) passes a 2-flop synchronizer; reset 0.
- Debounce, per sensor channel: a counter increments on each cycle where the synchronized sample differs from the debounced level and clears when they match. The debounced level toggles on the DEB_CYCLES-th consecutive differing sample, and the counter clears. Debounced levels reset to 0.
- Sticky alarm: alarm[i] sets on any cycle where debounced[i]=1. On an ack rising edge (synchronized ack 0→1), alarm[i] clears for every channel with debounced[i]=0. Channels still asserted stay set. If set and clear coincide, set wins.
- Colours: ch0 100 (red), ch1 101 (magenta), ch2 110 (yellow), ch3 001 (blue). IDLE shows 010 (green). GAP shows 000.
- Scheduler FSM, with round-robin pointer ptr[1:0] (reset 0) and current index idx[1:0]:
  - IDLE: if alarm≠0, select the first set bit searching ptr, ptr+1, … mod 4, and enter SHOW. Otherwise stay.
  - SHOW: count SLOT_CYCLES cycles, then enter GAP and set ptr=idx+1 mod 4. If alarm[idx] clears during SHOW, enter GAP on the next edge with the same ptr update.
  - GAP: count GAP_CYCLES cycles. At the end, go to SHOW with a new selection if alarm≠0, else go to IDLE.
- busy = (state≠IDLE).

## Timing
- Reset values: RGB=000, alarm=0000, busy=0, state IDLE, all counters 0, ptr=0. The first edge after reset release drives RGB=010.
- A mid-operation reset returns everything to the reset values immediately (asynchronous).
- RGB is registered from the next-state/next-index logic, so it changes on the same edge as the state.
- Sensor latency, counting edges from the first edge that samples the input high:
  - debounced level rises at edge DEB_CYCLES+2;
  - alarm[i] rises at edge DEB_CYCLES+3;
  - state goes to SHOW and RGB shows the colour at edge DEB_CYCLES+4.
  - With defaults: alarm at edge 19, colour at edge 20.
- Glitch rejection: any input pulse shorter than DEB_CYCLES cycles after synchronization has no effect.
- SHOW lasts exactly SLOT_CYCLES cycles unless aborted. GAP lasts exactly GAP_CYCLES cycles.
- Ack-to-clear latency: alarm clears on the 3rd edge after ack rises (2 sync edges plus the edge-detect register).
- Simultaneous events: several alarms setting on the same edge are served in pointer order. Ack during SHOW of a still-asserted channel changes nothing.

## Configuration
- AUTO_ALERT_BLINK_EN defined:
  - In SHOW, RGB = colour for the first BLINK_CYCLES cycles of each 2·BLINK_CYCLES window counted from SHOW entry, and 000 for the rest.
  - The blink counter restarts on each SHOW entry.
- AUTO_ALERT_BLINK_EN undefined: RGB holds the steady colour for the whole SHOW; the blink counter is not built.

## Test plan
- Reset release, all inputs 0 → RGB=010, alarm=0000, busy=0 from edge 1 and unchanged for 500 cycles.
- ct pulse of 10 cycles (DEB_CYCLES=16) → no alarm, RGB stays 010. ct held high → alarm=0001 at edge 19, RGB=100 at edge 20.
- ct, ot high together then released → repeating sequence: 100 for 64 cycles, 000 for 8, 110 for 64, 000 for 8. Ack pulse → alarm=0000, then GAP, then IDLE with RGB=010.
- ol held high, ack pressed → alarm[3] stays 1 and RGB continues cycling 001/000.
- cl alarm shown; release cl and ack mid-SHOW → RGB=000 on the edge after alarm[1] clears, GAP_CYCLES later RGB=010.
- Async rst asserted mid-SHOW → RGB=000, alarm=0000 immediately with no clock edge. With AUTO_ALERT_BLINK_EN: RGB toggles between colour and 000 every 8 cycles during SHOW.
